instr_ram_boot_ctrl: RTL and testbench
======================================

Name: instr_ram_boot_ctrl

Overview:
Sequences the instruction RAM and shares it between two users: a boot loader byte stream and the processor's instruction-fetch port. During a load it assembles incoming bytes into 32-bit little-endian words and writes them to consecutive word addresses, holding the CPU stalled. In RUN it passes fetch addresses straight to the RAM read port and returns data with a one-cycle registered latency. It sits between the boot-stream source (UART/SPI deserialiser), the CPU fetch stage and instruction_RAM_mem.

Parameters:
BASE_ADDR, 32'h0000_0000, byte address of the first loaded word.
DEPTH_WORDS, 1024, capacity in 32-bit words; a load beyond this is an overflow.
AUTO_RUN, 0, if 1 then reset exits to RUN (for a preloaded image) instead of IDLE.

Ports:
clk  in  1  system clock, rising edge; also drives the RAM wclk and rclk.
rst_n  in  1  asynchronous active-low reset.
boot_start  in  1  one-cycle request to begin a (re)load.
ld_valid  in  1  byte-stream valid.
ld_byte  in  8  stream byte.
ld_last  in  1  marks the final byte of the image; qualified by ld_valid.
ld_ready  out  1  controller accepts a byte this cycle.
fetch_req  in  1  CPU fetch request.
fetch_addr  in  32  CPU fetch byte address.
fetch_data  out  32  fetched instruction word.
fetch_valid  out  1  fetch_data is valid this cycle.
cpu_stall  out  1  CPU must hold its PC.
mem_din  out  32  RAM write data.
mem_we  out  1  RAM write enable.
mem_waddr  out  32  RAM write byte address.
mem_raddr  out  32  RAM read byte address.
mem_dout  in  32  RAM read data, registered inside the RAM (valid one cycle after mem_raddr).
load_done  out  1  one-cycle pulse when a load completes.
load_err  out  1  sticky overflow flag.
word_count  out  16  number of words written by the last or current load.

Behaviour:
- The clock is clk. Reset is rst_n, asynchronous and active-low. All state is cleared when rst_n is low.
- Reset values:
  - state = IDLE, or RUN if AUTO_RUN=1.
  - ld_ready=0, mem_we=0, mem_din=0, mem_waddr=BASE_ADDR.
  - fetch_valid=0, fetch_data=0, load_done=0, load_err=0, word_count=0.
  - cpu_stall=1 (0 if AUTO_RUN=1).
  - Byte index and partial-word register are cleared.
- States: IDLE, LOAD, FLUSH, RUN.
  - IDLE: cpu_stall=1, ld_ready=0. On boot_start, go to LOAD.
  - LOAD: cpu_stall=1, ld_ready=1. On entry, clear word_count, byte index and load_err.
    - A byte is accepted when ld_valid && ld_ready.
    - Accepted byte k (k=0..3) goes into word bits [8k+7:8k].
    - On the 4th byte, or on a byte with ld_last, the assembled word is registered. Unfilled upper bytes are zero.
    - On the next cycle: mem_we=1 for exactly one cycle, mem_waddr=BASE_ADDR+4*word_count, mem_din=word. word_count then increments.
    - ld_ready stays high across write cycles, so back-to-back bytes are allowed.
    - On the cycle a byte with ld_last is accepted, go to FLUSH.
  - FLUSH: ld_ready=0. The pending write, if any, completes this cycle. Next cycle: load_done pulses and the state goes to RUN.
  - RUN: cpu_stall=0, ld_ready=0.
    - mem_raddr = fetch_addr, combinational.
    - fetch_valid(t+1) = fetch_req(t); fetch_data(t+1) = mem_dout.
    - If boot_start is high in RUN, go to LOAD. cpu_stall=1 from the next cycle. A fetch issued in the same cycle still returns fetch_valid.
- mem_raddr = fetch_addr in all states. fetch_valid=0 in every cycle except the one after a RUN-state fetch_req.
- Overflow:
  - A write that would reach word_count==DEPTH_WORDS is suppressed (mem_we stays 0).
  - load_err is set and stays set until the next LOAD entry.
  - Remaining bytes keep being accepted and are dropped until ld_last arrives. word_count saturates at DEPTH_WORDS.
- boot_start while in LOAD or FLUSH is ignored.
- ld_last on byte index 0 writes a word with zero in bytes 1..3.
- Reset mid-load: the partial word is discarded, no further writes occur, and the state returns to the reset state.
- Address arithmetic is 32-bit wrap. Addresses are always word-aligned.

Test Plan:
- Basic load: boot_start, then bytes 13,05,00,00,93,00,10,00 with ld_last on the 8th -> writes 32'h00000513 @0x0 and 32'h00100093 @0x4; load_done pulses 2 cycles after the last accept; word_count=2; cpu_stall falls with RUN.
- Partial word: 5 bytes AA,BB,CC,DD,EE, last on EE -> writes 32'hDDCCBBAA @0x0 and 32'h000000EE @0x4.
- Fetch: after the basic load, fetch_req with fetch_addr=0x4 -> next cycle fetch_valid=1, fetch_data=32'h00100093. fetch_req=0 -> fetch_valid=0.
- Overflow: DEPTH_WORDS=4, stream of 20 bytes -> 4 writes (0x0..0xC), load_err=1, word_count=4, RUN reached. A following boot_start clears load_err.
- Reset mid-load: rst_n low after 2 bytes of a word -> no mem_we; outputs at reset values; IDLE with cpu_stall=1.
- Reload from RUN: boot_start in RUN while fetching -> the in-flight fetch returns, then cpu_stall=1 and ld_ready=1 from the next cycle; a new image overwrites from BASE_ADDR.

Source files
------------

// File: rtl/instr_ram_boot_ctrl.sv
// instr_ram_boot_ctrl: shares the instruction RAM between a boot byte stream
// and the CPU fetch port; packs bytes into LE words, then serves fetches.
// Ports: clk/rst_n; boot_start; ld_valid/ld_byte/ld_last/ld_ready stream;
// fetch_req/fetch_addr/fetch_data/fetch_valid/cpu_stall CPU side;
// mem_din/mem_we/mem_waddr/mem_raddr/mem_dout RAM side;
// load_done pulse, load_err sticky overflow, word_count words written.
module instr_ram_boot_ctrl #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          DEPTH_WORDS = 1024,
  parameter bit          AUTO_RUN    = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        boot_start,
  input  logic        ld_valid,
  input  logic [7:0]  ld_byte,
  input  logic        ld_last,
  output logic        ld_ready,
  input  logic        fetch_req,
  input  logic [31:0] fetch_addr,
  output logic [31:0] fetch_data,
  output logic        fetch_valid,
  output logic        cpu_stall,
  output logic [31:0] mem_din,
  output logic        mem_we,
  output logic [31:0] mem_waddr,
  output logic [31:0] mem_raddr,
  input  logic [31:0] mem_dout,
  output logic        load_done,
  output logic        load_err,
  output logic [15:0] word_count
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;
  localparam logic [1:0] S_RUN   = 2'd3;
  localparam logic [1:0] S_RST   = AUTO_RUN ? S_RUN : S_IDLE;
  localparam logic [15:0] DEPTH  = 16'(DEPTH_WORDS);

  logic [1:0]  state;
  logic [1:0]  bidx;
  logic [31:0] wbuf;
  logic [31:0] asm_w;
  logic        acc;
  logic        wdone;
  logic        full;
  logic        enter;

  assign ld_ready  = (state == S_LOAD);
  assign cpu_stall = (state != S_RUN);
  assign mem_raddr = fetch_addr;
  // RAM registers its output, so the data lines up with fetch_valid.
  assign fetch_data = fetch_valid ? mem_dout : '0;

  assign acc   = ld_valid && ld_ready;
  assign wdone = acc && ((bidx == 2'd3) || ld_last);
  assign full  = (word_count == DEPTH);
  assign enter = boot_start &&
                 ((state == S_IDLE) || (state == S_RUN));

  // wbuf is cleared per word, so unfilled upper bytes read as zero.
  always_comb begin
    asm_w = wbuf;
    asm_w[{bidx, 3'b000} +: 8] = ld_byte;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_RST;
      bidx        <= '0;
      wbuf        <= '0;
      mem_we      <= 1'b0;
      mem_din     <= '0;
      mem_waddr   <= BASE_ADDR;
      fetch_valid <= 1'b0;
      load_done   <= 1'b0;
      load_err    <= 1'b0;
      word_count  <= '0;
    end else begin
      mem_we      <= 1'b0;
      load_done   <= 1'b0;
      fetch_valid <= (state == S_RUN) && fetch_req;
      unique case (1'b1)
        enter: begin
          state      <= S_LOAD;
          bidx       <= '0;
          wbuf       <= '0;
          load_err   <= 1'b0;
          word_count <= '0;
        end
        acc: begin
          if (wdone) begin
            bidx <= '0;
            wbuf <= '0;
            if (full) begin
              load_err <= 1'b1;
            end else begin
              mem_we     <= 1'b1;
              mem_din    <= asm_w;
              mem_waddr  <= BASE_ADDR +
                            {14'd0, word_count, 2'b00};
              word_count <= word_count + 16'd1;
            end
          end else begin
            bidx <= bidx + 2'd1;
            wbuf <= asm_w;
          end
          if (ld_last) state <= S_FLUSH;
        end
        (state == S_FLUSH): begin
          load_done <= 1'b1;
          state     <= S_RUN;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_ram_boot_ctrl.sv
// tb_instr_ram_boot_ctrl: directed + randomized bench with a word-level
// reference model of the load image and a registered RAM model.
module tb_instr_ram_boot_ctrl;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        boot_start;
  logic        ld_valid;
  logic [7:0]  ld_byte;
  logic        ld_last;
  logic        ld_ready;
  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic [31:0] fetch_data;
  logic        fetch_valid;
  logic        cpu_stall;
  logic [31:0] mem_din;
  logic        mem_we;
  logic [31:0] mem_waddr;
  logic [31:0] mem_raddr;
  logic [31:0] mem_dout;
  logic        load_done;
  logic        load_err;
  logic [15:0] word_count;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] ram [0:15];
  logic [31:0] exp_mem [0:15];
  logic [63:0] wq [$];
  logic [7:0]  img [$];

  always #5 clk = ~clk;

  instr_ram_boot_ctrl #(
    .BASE_ADDR(32'h0),
    .DEPTH_WORDS(DEPTH),
    .AUTO_RUN(1'b0)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .boot_start(boot_start),
    .ld_valid(ld_valid),
    .ld_byte(ld_byte),
    .ld_last(ld_last),
    .ld_ready(ld_ready),
    .fetch_req(fetch_req),
    .fetch_addr(fetch_addr),
    .fetch_data(fetch_data),
    .fetch_valid(fetch_valid),
    .cpu_stall(cpu_stall),
    .mem_din(mem_din),
    .mem_we(mem_we),
    .mem_waddr(mem_waddr),
    .mem_raddr(mem_raddr),
    .mem_dout(mem_dout),
    .load_done(load_done),
    .load_err(load_err),
    .word_count(word_count)
  );

  // External RAM: synchronous write, registered read.
  always @(posedge clk) begin
    if (mem_we) ram[mem_waddr[5:2]] <= mem_din;
    mem_dout <= ram[mem_raddr[5:2]];
  end

  always @(negedge clk) begin
    if (mem_we) wq.push_back({mem_waddr, mem_din});
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit last);
    int bud;
    ld_valid = 1'b1;
    ld_byte  = b;
    ld_last  = last;
    bud = 0;
    while (!ld_ready && bud < 20) begin
      step();
      bud++;
    end
    if (bud == 20) chk("ready_timeout", {31'd0, ld_ready}, 32'd1);
    step();
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  // Reference: image is cut into 4-byte LE words, last one zero-padded;
  // only the first DEPTH words are written, at 4*i.
  task automatic run_load(input bit do_boot, input bit gaps,
                          input string tag);
    int nw;
    int nexp;
    logic [31:0] w [$];
    logic [31:0] cur;
    wq.delete();
    if (do_boot) begin
      boot_start = 1'b1;
      step();
      boot_start = 1'b0;
    end
    for (int i = 0; i < img.size(); i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) step();
      // boot_start during a load must have no effect
      boot_start = gaps && ($urandom_range(0, 3) == 0);
      send_byte(img[i], i == img.size() - 1);
    end
    boot_start = 1'b0;
    chk({tag, "_flush_ready"}, {31'd0, ld_ready}, 32'd0);
    chk({tag, "_flush_done"}, {31'd0, load_done}, 32'd0);
    step();
    chk({tag, "_done"}, {31'd0, load_done}, 32'd1);
    chk({tag, "_stall"}, {31'd0, cpu_stall}, 32'd0);
    step();
    chk({tag, "_done_pulse"}, {31'd0, load_done}, 32'd0);
    nw = (img.size() + 3) / 4;
    for (int k = 0; k < nw; k++) begin
      cur = 32'd0;
      for (int j = 0; j < 4; j++)
        if (4 * k + j < img.size())
          cur = cur | (32'(img[4 * k + j]) << (8 * j));
      w.push_back(cur);
    end
    nexp = (nw > DEPTH) ? DEPTH : nw;
    chk({tag, "_nwrites"}, wq.size(), nexp);
    for (int k = 0; k < nexp && k < wq.size(); k++) begin
      chk({tag, "_waddr"}, wq[k][63:32], 32'(4 * k));
      chk({tag, "_wdata"}, wq[k][31:0], w[k]);
      exp_mem[k] = w[k];
    end
    chk({tag, "_err"}, {31'd0, load_err}, {31'd0, nw > DEPTH});
    chk({tag, "_wc"}, {16'd0, word_count}, nexp);
  endtask

  task automatic rand_fetches(input int n);
    logic [1:0] ix;
    bit r;
    for (int i = 0; i < n; i++) begin
      r = 1'($urandom_range(0, 1));
      ix = 2'($urandom_range(0, 3));
      fetch_req = r;
      fetch_addr = {28'd0, ix, 2'b00};
      step();
      chk("rf_valid", {31'd0, fetch_valid}, {31'd0, r});
      if (r) chk("rf_data", fetch_data, exp_mem[ix]);
    end
    fetch_req = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      ram[i] = 32'd0;
      exp_mem[i] = 32'd0;
    end
    rst_n = 1'b0;
    boot_start = 1'b0;
    ld_valid = 1'b0;
    ld_byte = 8'd0;
    ld_last = 1'b0;
    fetch_req = 1'b0;
    fetch_addr = 32'd0;
    #12;
    chk("rst_ready", {31'd0, ld_ready}, 32'd0);
    chk("rst_stall", {31'd0, cpu_stall}, 32'd1);
    chk("rst_we", {31'd0, mem_we}, 32'd0);
    chk("rst_din", mem_din, 32'd0);
    chk("rst_waddr", mem_waddr, 32'd0);
    chk("rst_fvalid", {31'd0, fetch_valid}, 32'd0);
    chk("rst_fdata", fetch_data, 32'd0);
    chk("rst_done", {31'd0, load_done}, 32'd0);
    chk("rst_err", {31'd0, load_err}, 32'd0);
    chk("rst_wc", {16'd0, word_count}, 32'd0);
    rst_n = 1'b1;
    step();
    step();
    chk("idle_stall", {31'd0, cpu_stall}, 32'd1);
    chk("idle_ready", {31'd0, ld_ready}, 32'd0);

    img = {8'h13, 8'h05, 8'h00, 8'h00,
           8'h93, 8'h00, 8'h10, 8'h00};
    run_load(1'b1, 1'b0, "basic");
    chk("basic_w0", exp_mem[0], 32'h0000_0513);
    chk("basic_w1", exp_mem[1], 32'h0010_0093);

    fetch_req = 1'b1;
    fetch_addr = 32'h4;
    step();
    chk("fetch_valid", {31'd0, fetch_valid}, 32'd1);
    chk("fetch_data", fetch_data, 32'h0010_0093);
    fetch_req = 1'b0;
    step();
    chk("fetch_idle", {31'd0, fetch_valid}, 32'd0);

    img = {8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
    run_load(1'b1, 1'b0, "partial");
    chk("partial_w0", exp_mem[0], 32'hDDCC_BBAA);
    chk("partial_w1", exp_mem[1], 32'h0000_00EE);

    img.delete();
    for (int i = 0; i < 20; i++) img.push_back(8'($urandom));
    run_load(1'b1, 1'b1, "ovf");
    boot_start = 1'b1;
    step();
    boot_start = 1'b0;
    chk("ovf_clear", {31'd0, load_err}, 32'd0);
    chk("ovf_reload_ready", {31'd0, ld_ready}, 32'd1);
    img = {8'h01, 8'h02, 8'h03};
    run_load(1'b0, 1'b0, "after_ovf");

    // Reload from RUN with an in-flight fetch.
    fetch_req = 1'b1;
    fetch_addr = 32'h0;
    boot_start = 1'b1;
    step();
    boot_start = 1'b0;
    fetch_req = 1'b0;
    chk("rl_fvalid", {31'd0, fetch_valid}, 32'd1);
    chk("rl_fdata", fetch_data, exp_mem[0]);
    chk("rl_stall", {31'd0, cpu_stall}, 32'd1);
    chk("rl_ready", {31'd0, ld_ready}, 32'd1);
    img = {8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    run_load(1'b0, 1'b1, "reload");

    for (int it = 0; it < 8; it++) begin
      img.delete();
      repeat ($urandom_range(1, 20)) img.push_back(8'($urandom));
      run_load(1'b1, 1'b1, "rand");
      rand_fetches(5);
    end

    // Reset in the middle of a word.
    boot_start = 1'b1;
    step();
    boot_start = 1'b0;
    wq.delete();
    send_byte(8'h5A, 1'b0);
    send_byte(8'hA5, 1'b0);
    rst_n = 1'b0;
    #2;
    chk("mrst_we", {31'd0, mem_we}, 32'd0);
    chk("mrst_wc", {16'd0, word_count}, 32'd0);
    chk("mrst_stall", {31'd0, cpu_stall}, 32'd1);
    chk("mrst_waddr", mem_waddr, 32'd0);
    step();
    rst_n = 1'b1;
    ld_valid = 1'b1;
    ld_byte = 8'hFF;
    ld_last = 1'b1;
    repeat (4) step();
    ld_valid = 1'b0;
    ld_last = 1'b0;
    chk("mrst_idle_stall", {31'd0, cpu_stall}, 32'd1);
    chk("mrst_idle_ready", {31'd0, ld_ready}, 32'd0);
    chk("mrst_nowrite", wq.size(), 32'd0);
    chk("mrst_done", {31'd0, load_done}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
